// File: rtl/fp_accum_seq.sv
// fp_accum_seq: streaming single-precision accumulator.
// Feeds the running sum plus each accepted operand into an external
// combinational FP adder and registers the adder result as the new sum.
// A stream ends with an in_last beat. The sum, the beat count and a sticky
// exception flag are then held on a valid/ready output port until they are taken.
module fp_accum_seq #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_sub,
  input  logic               in_last,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  output logic               add_sub,
  input  logic [31:0]        add_result,
  input  logic               add_exception,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_exception
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t             state_reg;
  logic [31:0]        acc_reg;
  logic [COUNT_W-1:0] count_reg;
  logic               exc_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic               accept;

  // A beat is taken only when the registered ready is high, so in_ready
  // never depends combinationally on in_valid.
  assign accept = in_valid & in_ready_reg;

  // The adder operands come straight from the sum register and the input
  // beat. The adder result is consumed only when a beat is accepted.
  assign add_a   = acc_reg;
  assign add_b   = in_data;
  assign add_sub = in_sub;

  assign in_ready      = in_ready_reg;
  assign out_valid     = out_valid_reg;
  assign out_data      = acc_reg;
  assign out_count     = count_reg;
  assign out_exception = exc_reg;

  // Stream FSM: the state, the sum, the count, the sticky flag and the registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state_reg     <= IDLE;
      acc_reg       <= 32'h0000_0000;
      count_reg     <= '0;
      exc_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_reg <= add_result;
            exc_reg <= exc_reg | add_exception;
            if (count_reg != COUNT_MAX) begin
              count_reg <= count_reg + 1'b1;
            end
            if (in_last) begin
              state_reg     <= DONE;
              in_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              state_reg <= ACCUM;
            end
          end
        end
        DONE: begin
          // Hold the result until the consumer takes it. Then start over from +0.
          if (out_ready) begin
            state_reg     <= IDLE;
            acc_reg       <= 32'h0000_0000;
            count_reg     <= '0;
            exc_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          acc_reg       <= 32'h0000_0000;
          count_reg     <= '0;
          exc_reg       <= 1'b0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
